// File: rtl/instr_fetch_issue.sv
// rtl/instr_fetch_issue.sv - instruction fetch with one outstanding request, PC-tagged FIFO and issue handshake
module instr_fetch_issue #(
  parameter int                  PC_WIDTH = 16,
  parameter int                  DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  output logic                IMemReq,
  output logic [PC_WIDTH-1:0] IMemAddr,
  input  logic                IMemValid,
  input  logic [15:0]         IMemData,
  output logic                IssueValid,
  input  logic                IssueReady,
  output logic [15:0]         Instr,
  output logic [2:0]          OPCODE,
  output logic [PC_WIDTH-1:0] IssuePC,
  input  logic                BranchTaken,
  input  logic [PC_WIDTH-1:0] BranchTarget
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DISCARD} state_t;

  state_t              r_state, w_next;
  logic [PC_WIDTH-1:0] r_fpc, r_req_pc;
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [CW-1:0]       r_count;
  logic [15:0]         r_data [DEPTH];
  logic [PC_WIDTH-1:0] r_pc   [DEPTH];
  logic                w_space, w_req, w_push, w_pop;

  assign w_space = (r_count < CW'(DEPTH));

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (!BranchTaken && w_space) begin
          w_req  = 1'b1;
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // A flush before the response arrives must still swallow that response.
        if (BranchTaken)    w_next = IMemValid ? S_RUN : S_DISCARD;
        else if (IMemValid) w_next = S_RUN;
      end
      S_DISCARD: begin
        if (IMemValid) w_next = S_RUN;
      end
      default: w_next = S_RUN;
    endcase
  end

  assign w_push = (r_state == S_WAIT) && IMemValid && !BranchTaken;
  assign w_pop  = IssueValid && IssueReady && !BranchTaken;

  assign IMemReq  = w_req & ~Reset;
  assign IMemAddr = IMemReq ? r_fpc : '0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_RUN;
      r_fpc    <= RESET_PC;
      r_req_pc <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      if (BranchTaken) begin
        r_fpc <= BranchTarget;
      end else if (w_req) begin
        r_fpc    <= r_fpc + PC_WIDTH'(1);
        r_req_pc <= r_fpc;
      end
      if (BranchTaken) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        if (w_push && !w_pop)      r_count <= r_count + CW'(1);
        else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_data[r_wptr] <= IMemData;
      r_pc[r_wptr]   <= r_req_pc;
    end
  end

  assign IssueValid = (r_count != '0);
  assign Instr      = IssueValid ? r_data[r_rptr] : 16'h0000;
  assign OPCODE     = Instr[15:13];
  assign IssuePC    = IssueValid ? r_pc[r_rptr] : '0;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// tb/tb_instr_fetch_issue.sv - directed bench for instr_fetch_issue
module tb_instr_fetch_issue;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        IMemReq, IssueValid;
  logic [15:0] IMemAddr, Instr, IssuePC;
  logic [2:0]  OPCODE;
  logic        IMemValid = 1'b0;
  logic [15:0] IMemData = 16'h0000;
  logic        IssueReady = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [15:0] BranchTarget = 16'h0000;

  logic        IMemReq_w, IssueValid_w;
  logic [15:0] IMemAddr_w, Instr_w, IssuePC_w;
  logic [2:0]  OPCODE_w;
  logic        IMemValid_w = 1'b0;
  logic [15:0] IMemData_w = 16'h0000;
  logic        IssueReady_w = 1'b1;
  logic        BranchTaken_w = 1'b0;
  logic [15:0] BranchTarget_w = 16'h0000;

  instr_fetch_issue #(.PC_WIDTH(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .Clock(Clock), .Reset(Reset), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemValid(IMemValid), .IMemData(IMemData), .IssueValid(IssueValid),
    .IssueReady(IssueReady), .Instr(Instr), .OPCODE(OPCODE), .IssuePC(IssuePC),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget)
  );

  instr_fetch_issue #(.PC_WIDTH(16), .DEPTH(4), .RESET_PC(16'hFFFF)) dut_w (
    .Clock(Clock), .Reset(Reset), .IMemReq(IMemReq_w), .IMemAddr(IMemAddr_w),
    .IMemValid(IMemValid_w), .IMemData(IMemData_w), .IssueValid(IssueValid_w),
    .IssueReady(IssueReady_w), .Instr(Instr_w), .OPCODE(OPCODE_w), .IssuePC(IssuePC_w),
    .BranchTaken(BranchTaken_w), .BranchTarget(BranchTarget_w)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  logic [15:0] mem [256];
  logic [15:0] req_q[$], pc_q[$], ins_q[$], req_w_q[$], pcw_q[$];
  logic [2:0]  op_q[$];

  // Memory model: response strobe appears 'lat' cycles after the request cycle.
  int cd = 0;
  logic [15:0] paddr = 16'h0000;
  always @(negedge Clock) begin
    IMemValid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        IMemValid = 1'b1;
        IMemData  = mem[paddr[7:0]];
      end
    end
    if (IMemReq && cd == 0) begin
      paddr = IMemAddr;
      cd    = lat;
      req_q.push_back(IMemAddr);
    end
    if (IssueValid && IssueReady && !BranchTaken) begin
      pc_q.push_back(IssuePC);
      op_q.push_back(OPCODE);
      ins_q.push_back(Instr);
    end
  end

  int cd_w = 0;
  logic [15:0] paddr_w = 16'h0000;
  always @(negedge Clock) begin
    IMemValid_w = 1'b0;
    if (cd_w > 0) begin
      cd_w--;
      if (cd_w == 0) begin
        IMemValid_w = 1'b1;
        IMemData_w  = mem[paddr_w[7:0]];
      end
    end
    if (IMemReq_w && cd_w == 0) begin
      paddr_w = IMemAddr_w;
      cd_w    = 1;
      req_w_q.push_back(IMemAddr_w);
    end
    if (IssueValid_w && IssueReady_w) pcw_q.push_back(IssuePC_w);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input int l, input logic rdy);
    Reset = 1'b1;
    BranchTaken = 1'b0;
    IssueReady = rdy;
    lat = l;
    tick(4);
    req_q.delete(); pc_q.delete(); op_q.delete(); ins_q.delete();
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    tick(2);
    @(negedge Clock);
    total++;
    if ({IMemReq, IMemAddr, IssueValid} !== 18'h0) begin
      bad++; $display("FAIL reset_fetch got=%b/%h/%b exp=0/0000/0", IMemReq, IMemAddr, IssueValid);
    end
    total++;
    if ({Instr, OPCODE, IssuePC} !== 35'h0) begin
      bad++; $display("FAIL reset_head got=%h/%b/%h exp=0000/000/0000", Instr, OPCODE, IssuePC);
    end
  endtask

  task automatic test_basic;
    logic [2:0] exp_op [4];
    exp_op = '{3'b011, 3'b001, 3'b101, 3'b110};
    do_reset(1, 1'b1);
    @(negedge Clock);
    total++;
    if ({IMemReq, IMemAddr, IssueValid} !== {1'b1, 16'h0000, 1'b0}) begin
      bad++; $display("FAIL basic_first_req got=%b/%h/%b exp=1/0000/0", IMemReq, IMemAddr, IssueValid);
    end
    @(negedge Clock);
    total++;
    if (IssueValid !== 1'b0) begin bad++; $display("FAIL basic_lat_c1 got=%b exp=0", IssueValid); end
    @(negedge Clock);
    total++;
    if ({IssueValid, OPCODE, IssuePC} !== {1'b1, 3'b011, 16'h0000}) begin
      bad++; $display("FAIL basic_lat_c2 got=%b/%b/%h exp=1/011/0000", IssueValid, OPCODE, IssuePC);
    end
    tick(10);
    total++;
    if (pc_q.size() < 4 || req_q.size() < 4) begin
      bad++; $display("FAIL basic_count got=%0d/%0d exp>=4", pc_q.size(), req_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({req_q[i], pc_q[i], op_q[i], ins_q[i]} !== {16'(i), 16'(i), exp_op[i], mem[i]}) begin
        bad++; $display("FAIL basic_item[%0d] got=%h/%h/%b/%h exp=%h/%h/%b/%h", i,
                        req_q[i], pc_q[i], op_q[i], ins_q[i], 16'(i), 16'(i), exp_op[i], mem[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset(1, 1'b0);
    tick(20);
    total++;
    if (req_q.size() !== 4) begin bad++; $display("FAIL bp_req_count got=%0d exp=4", req_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (req_q[i] !== 16'(i)) begin bad++; $display("FAIL bp_req[%0d] got=%h exp=%h", i, req_q[i], 16'(i)); end
    end
    @(negedge Clock);
    total++;
    if ({IMemReq, IssueValid, IssuePC, Instr} !== {1'b0, 1'b1, 16'h0000, mem[0]}) begin
      bad++; $display("FAIL bp_hold got=%b/%b/%h/%h exp=0/1/0000/%h", IMemReq, IssueValid, IssuePC, Instr, mem[0]);
    end
    tick(1);
    IssueReady = 1'b1;
    tick(12);
    total++;
    if (pc_q.size() < 4 || req_q.size() < 5) begin
      bad++; $display("FAIL bp_resume_count got=%0d/%0d exp>=4/5", pc_q.size(), req_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (pc_q[i] !== 16'(i)) begin bad++; $display("FAIL bp_pc[%0d] got=%h exp=%h", i, pc_q[i], 16'(i)); end
    end
    total++;
    if (req_q[4] !== 16'h0004) begin bad++; $display("FAIL bp_resume_addr got=%h exp=0004", req_q[4]); end
  endtask

  task automatic test_flush_wait;
    int stale;
    do_reset(3, 1'b1);
    tick(1);
    BranchTaken = 1'b1;
    BranchTarget = 16'h0040;
    tick(1);
    BranchTaken = 1'b0;
    @(negedge Clock);
    total++;
    if ({IMemReq, IssueValid} !== 2'b00) begin
      bad++; $display("FAIL fw_discard got=%b/%b exp=0/0", IMemReq, IssueValid);
    end
    tick(12);
    total++;
    if (req_q.size() < 2 || req_q[0] !== 16'h0000 || req_q[1] !== 16'h0040) begin
      bad++; $display("FAIL fw_redirect got=%0d/%h/%h exp=>=2/0000/0040", req_q.size(), req_q[0], req_q[1]);
    end
    total++;
    if (pc_q.size() < 1 || pc_q[0] !== 16'h0040 || ins_q[0] !== mem[8'h40]) begin
      bad++; $display("FAIL fw_first_issue got=%0d/%h/%h exp=>=1/0040/%h", pc_q.size(), pc_q[0], ins_q[0], mem[8'h40]);
    end
    stale = 0;
    foreach (pc_q[k]) if (pc_q[k] == 16'h0000) stale++;
    total++;
    if (stale !== 0) begin bad++; $display("FAIL fw_stale got=%0d exp=0", stale); end
  endtask

  task automatic test_flush_push_pop;
    do_reset(1, 1'b0);
    tick(3);
    total++;
    if (IssueValid !== 1'b1) begin bad++; $display("FAIL fpp_precond got=%b exp=1", IssueValid); end
    IssueReady = 1'b1;
    BranchTaken = 1'b1;
    BranchTarget = 16'h0080;
    tick(1);
    BranchTaken = 1'b0;
    @(negedge Clock);
    total++;
    if ({IssueValid, IMemReq, IMemAddr} !== {1'b0, 1'b1, 16'h0080}) begin
      bad++; $display("FAIL fpp_after got=%b/%b/%h exp=0/1/0080", IssueValid, IMemReq, IMemAddr);
    end
    tick(6);
    total++;
    if (pc_q.size() < 1 || pc_q[0] !== 16'h0080 || ins_q[0] !== mem[8'h80]) begin
      bad++; $display("FAIL fpp_issue got=%0d/%h/%h exp=>=1/0080/%h", pc_q.size(), pc_q[0], ins_q[0], mem[8'h80]);
    end
  endtask

  task automatic test_wrap;
    total++;
    if (req_w_q.size() < 2 || req_w_q[0] !== 16'hFFFF || req_w_q[1] !== 16'h0000) begin
      bad++; $display("FAIL wrap_addr got=%0d/%h/%h exp=>=2/ffff/0000", req_w_q.size(), req_w_q[0], req_w_q[1]);
    end
    total++;
    if (pcw_q.size() < 2 || pcw_q[0] !== 16'hFFFF || pcw_q[1] !== 16'h0000) begin
      bad++; $display("FAIL wrap_pc got=%0d/%h/%h exp=>=2/ffff/0000", pcw_q.size(), pcw_q[0], pcw_q[1]);
    end
  endtask

  task automatic test_async_reset;
    do_reset(3, 1'b0);
    tick(5);
    total++;
    if ({IssueValid, IMemReq} !== 2'b10) begin
      bad++; $display("FAIL ar_precond got=%b/%b exp=1/0", IssueValid, IMemReq);
    end
    Reset = 1'b1;
    #1;
    total++;
    if ({IMemReq, IMemAddr, IssueValid, Instr, OPCODE, IssuePC} !== 53'h0) begin
      bad++; $display("FAIL ar_immediate got=%b/%h/%b/%h/%b/%h exp=all zero",
                      IMemReq, IMemAddr, IssueValid, Instr, OPCODE, IssuePC);
    end
    req_q.delete(); pc_q.delete(); op_q.delete(); ins_q.delete();
    tick(2);
    Reset = 1'b0;
    @(negedge Clock);
    total++;
    if ({IMemReq, IMemAddr} !== {1'b1, 16'h0000}) begin
      bad++; $display("FAIL ar_first_req got=%b/%h exp=1/0000", IMemReq, IMemAddr);
    end
    IssueReady = 1'b1;
    tick(10);
    total++;
    if (pc_q.size() < 1 || pc_q[0] !== 16'h0000 || ins_q[0] !== mem[0]) begin
      bad++; $display("FAIL ar_issue got=%0d/%h/%h exp=>=1/0000/%h", pc_q.size(), pc_q[0], ins_q[0], mem[0]);
    end
    total++;
    if (req_q.size() < 2 || req_q[0] !== 16'h0000 || req_q[1] !== 16'h0001) begin
      bad++; $display("FAIL ar_reqs got=%0d/%h/%h exp=>=2/0000/0001", req_q.size(), req_q[0], req_q[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h1357 + 16'h0101);
    mem[0] = 16'h6005;
    mem[1] = 16'h2003;
    mem[2] = 16'hA001;
    mem[3] = 16'hC002;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_wait();
    test_flush_push_pop();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
